// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing source for the display pipeline. A clock divider produces a one-cycle pixel
// enable; on every pixel enable the column/line counters advance across the full raster
// (active area plus porches and sync). Sync, blank and the line/frame strobes are all
// registered from the next-state counter values, so every output changes on the same clock
// edge as the counters it describes.
//
// Ports
//   clk         in   1   system clock, single domain
//   rst         in   1   synchronous reset, active-high
//   pix_en      out  1   one-clk pulse per pixel period; counters advance on the following edge
//   hcounter    out  11  pixel column, 0..H_TOTAL-1
//   vcounter    out  11  line number, 0..V_TOTAL-1
//   hsync       out  1   horizontal sync, equals SYNC_POL while asserted
//   vsync       out  1   vertical sync, equals SYNC_POL while asserted
//   blank       out  1   high outside the visible area
//   line_tick   out  1   one-clk pulse in the cycle hcounter becomes 0
//   frame_tick  out  1   one-clk pulse in the cycle (hcounter, vcounter) becomes (0, V_ACTIVE)
//
// Constraints on parameters: CLK_DIV >= 1, H_TOTAL <= 2047, V_TOTAL <= 2047.
// ---------------------------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [10:0] hcounter,
    output logic [10:0] vcounter,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        line_tick,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A one-bit divider is kept even for CLK_DIV == 1; it simply stays at zero.
    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    localparam logic [10:0] HMax       = 11'(H_TOTAL - 1);
    localparam logic [10:0] VMax       = 11'(V_TOTAL - 1);
    localparam logic [10:0] HActive    = 11'(H_ACTIVE);
    localparam logic [10:0] VActive    = 11'(V_ACTIVE);
    localparam logic [10:0] HSyncStart = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VSyncStart = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DivW-1:0] div_q, div_d;
    logic            pix_en_q, pix_en_d;
    logic [10:0]     hcount_q, hcount_d;
    logic [10:0]     vcount_q, vcount_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            blank_q, blank_d;
    logic            line_tick_q, line_tick_d;
    logic            frame_tick_q, frame_tick_d;
    logic            h_wrap;

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        // Divider: pix_en is registered so that it is high exactly while div == CLK_DIV-1.
        div_d    = (div_q == DivMax) ? '0 : div_q + 1'b1;
        pix_en_d = (div_d == DivMax);

        h_wrap   = (hcount_q == HMax);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en_q) begin
            if (h_wrap) begin
                hcount_d = '0;
                vcount_d = (vcount_q == VMax) ? '0 : vcount_q + 11'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end

        // Decode from the next-state counters so the registered outputs line up with them.
        hsync_d = ((hcount_d >= HSyncStart) && (hcount_d < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((vcount_d >= VSyncStart) && (vcount_d < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        blank_d = (hcount_d >= HActive) || (vcount_d >= VActive);

        // Strobes only fire on a real wrap, never on the counters being forced to 0 by reset.
        line_tick_d  = pix_en_q && h_wrap;
        frame_tick_d = line_tick_d && (vcount_d == VActive);
    end

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            pix_en_q     <= 1'b0;
            hcount_q     <= '0;
            vcount_q     <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            blank_q      <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            pix_en_q     <= pix_en_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            blank_q      <= blank_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pix_en     = pix_en_q;
    assign hcounter   = hcount_q;
    assign vcounter   = vcount_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign blank      = blank_q;
    assign line_tick  = line_tick_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share clk/rst:
//   dut_a  small raster (H 8/2/3/2 = 15, V 6/2/2/1 = 11), CLK_DIV=2, active-low sync
//   dut_b  default 640x480 timing, CLK_DIV=2 (one full line exercised)
//   dut_c  small raster, CLK_DIV=1, active-high sync
// Every cycle each instance is compared against a closed-form model that derives the raster
// position from the number of clock edges since reset; directed checks cover reset, first
// pixel enable, sync windows, tick periods and a mid-frame reset.
// Output word layout: [27]=pix_en [26:16]=h [15:5]=v [4]=hsync [3]=vsync [2]=blank
//                     [1]=line_tick [0]=frame_tick
// ---------------------------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst;

    logic        a_pe, a_hs, a_vs, a_bl, a_lt, a_ft;
    logic [10:0] a_h, a_v;
    logic        b_pe, b_hs, b_vs, b_bl, b_lt, b_ft;
    logic [10:0] b_h, b_v;
    logic        c_pe, c_hs, c_vs, c_bl, c_lt, c_ft;
    logic [10:0] c_h, c_v;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .pix_en(a_pe), .hcounter(a_h), .vcounter(a_v),
        .hsync(a_hs), .vsync(a_vs), .blank(a_bl), .line_tick(a_lt), .frame_tick(a_ft)
    );

    vga_timing_gen dut_b (
        .clk(clk), .rst(rst), .pix_en(b_pe), .hcounter(b_h), .vcounter(b_v),
        .hsync(b_hs), .vsync(b_vs), .blank(b_bl), .line_tick(b_lt), .frame_tick(b_ft)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) dut_c (
        .clk(clk), .rst(rst), .pix_en(c_pe), .hcounter(c_h), .vcounter(c_v),
        .hsync(c_hs), .vsync(c_vs), .blank(c_bl), .line_tick(c_lt), .frame_tick(c_ft)
    );

    logic [31:0] word_a, word_b, word_c;
    assign word_a = {4'b0, a_pe, a_h, a_v, a_hs, a_vs, a_bl, a_lt, a_ft};
    assign word_b = {4'b0, b_pe, b_h, b_v, b_hs, b_vs, b_bl, b_lt, b_ft};
    assign word_c = {4'b0, c_pe, c_h, c_v, c_hs, c_vs, c_bl, c_lt, c_ft};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pixel advances completed after k non-reset edges (k = 0 is the reset state).
    function automatic int advances(input int k, input int d);
        int a;
        if (k <= 0) return 0;
        a = k / d;
        if (d == 1) a = a - 1;
        return a;
    endfunction

    function automatic logic [31:0] model(input int k, input int d,
                                          input int ha, input int hf, input int hs, input int hb,
                                          input int va, input int vf, input int vs, input int vb,
                                          input bit pol);
        int   ht, vt, adv, h, v;
        logic pe, hsy, vsy, bl, lt, ft;
        ht  = ha + hf + hs + hb;
        vt  = va + vf + vs + vb;
        adv = advances(k, d);
        h   = adv % ht;
        v   = (adv / ht) % vt;
        pe  = (k >= 1) && ((k % d) == (d - 1));
        hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
        vsy = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
        bl  = (h >= ha) || (v >= va);
        lt  = (k >= 1) && (advances(k - 1, d) != adv) && (h == 0);
        ft  = lt && (v == va);
        return {4'b0, pe, 11'(h), 11'(v), hsy, vsy, bl, lt, ft};
    endfunction

    // Edges since reset; the reference models run off this alone.
    int k = 0;
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    logic armed  = 1'b0;
    logic phase1 = 1'b0;

    int last_ft_a = -1, last_lt_a = -1, last_ft_c = -1, last_lt_b = -1;
    int n_ft_a = 0, n_lt_b = 0;
    int b_hs_cnt = 0, b_hs_min = 4095, b_hs_max = -1;
    int a_vs_min = 4095, a_vs_max = -1;

    always @(negedge clk) begin
        if (armed) begin
            check("a_cycle", word_a, model(k, 2, 8, 2, 3, 2, 6, 2, 2, 1, 1'b0));
            check("b_cycle", word_b, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            check("c_cycle", word_c, model(k, 1, 8, 2, 3, 2, 6, 2, 2, 1, 1'b1));

            if (k == 0) begin
                last_ft_a = -1;
                last_lt_a = -1;
                last_ft_c = -1;
                last_lt_b = -1;
            end
            if (a_ft) begin
                check("a_ft_pos", {10'b0, a_h, a_v}, {10'b0, 11'd0, 11'd6});
                if (last_ft_a >= 0) check("a_ft_period", 32'(k - last_ft_a), 32'd330);
                last_ft_a = k;
                n_ft_a++;
            end
            if (a_lt) begin
                if (last_lt_a >= 0) check("a_lt_period", 32'(k - last_lt_a), 32'd30);
                last_lt_a = k;
            end
            if (c_ft) begin
                if (last_ft_c >= 0) check("c_ft_period", 32'(k - last_ft_c), 32'd165);
                last_ft_c = k;
            end
            if (b_lt) begin
                if (last_lt_b >= 0) check("b_lt_period", 32'(k - last_lt_b), 32'd1600);
                last_lt_b = k;
                n_lt_b++;
            end
            if (phase1 && b_v == 11'd0 && !b_hs) begin
                b_hs_cnt++;
                if (int'(b_h) < b_hs_min) b_hs_min = int'(b_h);
                if (int'(b_h) > b_hs_max) b_hs_max = int'(b_h);
            end
            if (phase1 && !a_vs) begin
                if (int'(a_v) < a_vs_min) a_vs_min = int'(a_v);
                if (int'(a_v) > a_vs_max) a_vs_max = int'(a_v);
            end
        end
    end

    initial begin
        bit found;
        int ft_k;
        rst = 1'b1;
        @(posedge clk);
        #1 armed = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state: (0,0), not blanked, sync deasserted, no strobes.
        check("a_reset", word_a, 32'h0000_0018);
        check("c_reset", word_c, 32'h0000_0000);
        rst    = 1'b0;
        phase1 = 1'b1;

        @(negedge clk);
        check("a_pix_first", {31'b0, a_pe}, 32'd1);
        check("c_pix_first", {31'b0, c_pe}, 32'd1);
        check("a_h_first", {21'b0, a_h}, 32'd0);
        @(negedge clk);
        check("a_pix_second", {31'b0, a_pe}, 32'd0);
        check("a_h_second", {21'b0, a_h}, 32'd1);
        check("c_h_second", {21'b0, c_h}, 32'd1);

        repeat (3300) @(negedge clk);
        phase1 = 1'b0;

        check("b_hsync_clks", 32'(b_hs_cnt), 32'd192);
        check("b_hsync_first", 32'(b_hs_min), 32'd656);
        check("b_hsync_last", 32'(b_hs_max), 32'd751);
        check("a_vsync_first", 32'(a_vs_min), 32'd8);
        check("a_vsync_last", 32'(a_vs_max), 32'd9);
        check("a_ft_seen", 32'(n_ft_a >= 3), 32'd1);
        check("b_lt_seen", 32'(n_lt_b >= 2), 32'd1);

        // Mid-frame reset at (4,3) on the small raster.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (a_h == 11'd4 && a_v == 11'd3) found = 1'b1;
        end
        check("a_reach_4_3", {31'b0, found}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("a_mid_reset", word_a, 32'h0000_0018);
        check("c_mid_reset", word_c, 32'h0000_0000);
        check("b_mid_reset", word_b, 32'h0000_0018);
        rst = 1'b0;

        // 90 pixels to reach (0,6) at two clocks each.
        found = 1'b0;
        ft_k  = -1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (a_ft) begin
                found = 1'b1;
                ft_k  = k;
            end
        end
        check("a_ft_after_reset", 32'(ft_k), 32'd180);
        repeat (400) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
